// File: rtl/tlp_pkg.sv
// Shared TLP framing definitions: K-codes, type codes, fmt_type values, FSM states.
// Imported by the framer and by the receiver side.
package tlp_pkg;

  localparam int MAX_BYTES = 20;

  localparam logic [4:0] MIN_LEN = 5'd4;

  localparam logic [7:0] K_STP  = 8'hFB;
  localparam logic [7:0] K_END  = 8'hFD;
  localparam logic [7:0] K_IDLE = 8'h00;

  localparam logic [3:0] T_MRD    = 4'd0;
  localparam logic [3:0] T_MWR    = 4'd1;
  localparam logic [3:0] T_IORD   = 4'd2;
  localparam logic [3:0] T_IOWR   = 4'd3;
  localparam logic [3:0] T_CFGRD0 = 4'd4;
  localparam logic [3:0] T_CFGWR0 = 4'd5;
  localparam logic [3:0] T_CFGRD1 = 4'd6;
  localparam logic [3:0] T_CFGWR1 = 4'd7;
  localparam logic [3:0] T_CPL    = 4'd8;
  localparam logic [3:0] T_CPLD   = 4'd9;

  localparam logic [7:0] FMT_MRD    = 8'h00;
  localparam logic [7:0] FMT_MWR    = 8'h40;
  localparam logic [7:0] FMT_IORD   = 8'h02;
  localparam logic [7:0] FMT_IOWR   = 8'h42;
  localparam logic [7:0] FMT_CFGRD0 = 8'h04;
  localparam logic [7:0] FMT_CFGWR0 = 8'h44;
  localparam logic [7:0] FMT_CFGRD1 = 8'h05;
  localparam logic [7:0] FMT_CFGWR1 = 8'h45;
  localparam logic [7:0] FMT_CPL    = 8'h0A;
  localparam logic [7:0] FMT_CPLD   = 8'h4A;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STP,
    S_BODY,
    S_END
  } state_t;

endpackage

// File: rtl/tlp_fmt_enc.sv
// Combinational map from tlp_type to the fmt_type header byte.
// valid is low for the reserved codes 10-15.
module tlp_fmt_enc
  import tlp_pkg::*;
(
  input  logic [3:0] tlp_type,
  output logic [7:0] fmt_type,
  output logic       valid
);

  always_comb begin
    fmt_type = 8'h00;
    valid    = 1'b1;
    unique case (1'b1)
      (tlp_type == T_MRD):    fmt_type = FMT_MRD;
      (tlp_type == T_MWR):    fmt_type = FMT_MWR;
      (tlp_type == T_IORD):   fmt_type = FMT_IORD;
      (tlp_type == T_IOWR):   fmt_type = FMT_IOWR;
      (tlp_type == T_CFGRD0): fmt_type = FMT_CFGRD0;
      (tlp_type == T_CFGWR0): fmt_type = FMT_CFGWR0;
      (tlp_type == T_CFGRD1): fmt_type = FMT_CFGRD1;
      (tlp_type == T_CFGWR1): fmt_type = FMT_CFGWR1;
      (tlp_type == T_CPL):    fmt_type = FMT_CPL;
      (tlp_type == T_CPLD):   fmt_type = FMT_CPLD;
      default:                valid    = 1'b0;
    endcase
  end

endmodule

// File: rtl/tlp_framer.sv
// Frames a captured TLP as STP, fmt_type, payload bytes, END on an 8-bit symbol lane.
// Outputs are registered from the next-state decode so they line up with the state.
module tlp_framer #(
  parameter int MAX_BYTES = tlp_pkg::MAX_BYTES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             tlp_type,
  input  logic [4:0]             tlp_len,
  input  logic [8*MAX_BYTES-1:0] tlp_data,
  output logic                   ready,
  output logic [7:0]             data_out,
  output logic                   datak,
  output logic                   done,
  output logic                   err,
  output logic [7:0]             TLP_count
);

  import tlp_pkg::*;

  localparam logic [4:0] MAX_LEN = 5'(MAX_BYTES);
  localparam logic [4:0] LAST    = 5'(MAX_BYTES - 1);

  state_t state_q, state_d;

  logic [4:0] idx_q, idx_d;
  logic [4:0] len_q;
  logic [7:0] fmt_q;
  logic [MAX_BYTES-1:0][7:0] bytes_q;

  logic [7:0] fmt_w;
  logic       fmt_ok;
  logic       accept, len_ok, go, bad;
  logic [7:0] sym_d;
  logic       k_d;

  tlp_fmt_enc u_enc (
    .tlp_type (tlp_type),
    .fmt_type (fmt_w),
    .valid    (fmt_ok)
  );

  assign accept = (state_q == S_IDLE) && start;
  assign len_ok = (tlp_len >= MIN_LEN) && (tlp_len <= MAX_LEN);
  assign go     = accept && fmt_ok && len_ok;
  assign bad    = accept && !(fmt_ok && len_ok);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: if (go) state_d = S_STP;
      S_STP: begin
        state_d = S_BODY;
        idx_d   = 5'd0;
      end
      S_BODY: begin
        if (idx_q == len_q - 5'd1) state_d = S_END;
        else idx_d = idx_q + 5'd1;
      end
      S_END:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Symbol for the state being entered; byte0 carries fmt_type.
  always_comb begin
    sym_d = K_IDLE;
    k_d   = 1'b0;
    unique case (state_d)
      S_STP: begin
        sym_d = K_STP;
        k_d   = 1'b1;
      end
      S_BODY: begin
        if (idx_d == 5'd0) sym_d = fmt_q;
        else sym_d = bytes_q[LAST - idx_d];
      end
      S_END: begin
        sym_d = K_END;
        k_d   = 1'b1;
      end
      default: sym_d = K_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= 5'd0;
      ready     <= 1'b1;
      data_out  <= K_IDLE;
      datak     <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      TLP_count <= 8'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ready    <= (state_d == S_IDLE);
      data_out <= sym_d;
      datak    <= k_d;
      done     <= (state_d == S_END);
      err      <= bad;
      if (state_d == S_END) TLP_count <= TLP_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      len_q   <= tlp_len;
      fmt_q   <= fmt_w;
      bytes_q <= tlp_data;
    end
  end

endmodule

// File: doc/tlp_framer.md
TLP_FRAMER -- requirements
Module: tlp_framer

Interface
REQ-001 Parameter MAX_BYTES, 20, maximum TLP length in bytes (header plus payload); tlp_data width is 8*MAX_BYTES.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 start  input  1  request to transmit the TLP presented on tlp_type/tlp_len/tlp_data.
REQ-005 tlp_type  input  4  type code: 0 MRd, 1 MWr, 2 IORd, 3 IOWr, 4 CfgRd0, 5 CfgWr0, 6 CfgRd1, 7 CfgWr1, 8 Cpl, 9 CplD; 10-15 invalid.
REQ-006 tlp_len  input  5  TLP length in bytes, legal range 4..20.
REQ-007 tlp_data  input  160  TLP bytes, MSB first: byte0 = [159:152], byte k = [159-8k -: 8].
REQ-008 ready  output  1  high when start will be accepted.
REQ-009 data_out  output  8  transmitted symbol.
REQ-010 datak  output  1  high when data_out is a K-symbol.
REQ-011 done  output  1  one-cycle pulse coincident with the END symbol.
REQ-012 err  output  1  one-cycle pulse when a start is rejected.
REQ-013 TLP_count  output  8  number of TLPs fully transmitted, modulo 256.

Function
REQ-014 FSM states: IDLE, STP, BODY, END; all outputs are registered.
REQ-015 IDLE: ready=1, data_out=8'h00, datak=0; start with ready=1 is accepted and all inputs are captured into internal registers.
REQ-016 An accepted start with legal tlp_type and tlp_len moves IDLE->STP; data_out=8'hFB with datak=1 appears on the cycle after the accepting edge (latency 1).
REQ-017 An accepted start with tlp_type>9 or tlp_len outside 4..20 leaves the FSM in IDLE, pulses err on the next cycle, and emits no symbols.
REQ-018 BODY emits tlp_len bytes with datak=0, one per cycle; byte0 is replaced by the fmt_type value for the captured type, and bytes 1..len-1 are taken unchanged from the captured data.
REQ-019 fmt_type table: MRd 00, MWr 40, IORd 02, IOWr 42, CfgRd0 04, CfgWr0 44, CfgRd1 05, CfgWr1 45, Cpl 0A, CplD 4A (hex).
REQ-020 The END state emits 8'hFD with datak=1, pulses done, and increments TLP_count (255 wraps to 0); the next state is IDLE.
REQ-021 A frame occupies exactly tlp_len+2 cycles; ready=0 from the accept edge until the cycle after END.
REQ-022 start while ready=0 is ignored without err; captured inputs do not change mid-frame.
REQ-023 Minimum gap between frames is one IDLE cycle (8'h00, datak=0); start held high continuously produces back-to-back frames separated by exactly one IDLE symbol.
REQ-024 start and an invalid request in the same cycle as END are ignored, because ready=0.

Reset
REQ-025 With reset=0 at a rising edge: state=IDLE, ready=1 on the following cycle, data_out=8'h00, datak=0, done=0, err=0, TLP_count=0.
REQ-026 Reset mid-frame aborts the frame immediately: no END symbol is emitted, no done pulse occurs, and the count is cleared.

Structure
REQ-027 Shared package tlp_pkg holds the K-codes (STP=FB, END=FD, IDLE=00), the tlp_type code constants, the fmt_type table, MAX_BYTES, and the FSM state encoding; it is shared with the receiver.
REQ-028 One combinational sub-module, tlp_fmt_enc, maps tlp_type to fmt_type plus a valid flag; the FSM, byte counter, and capture registers reside in tlp_framer.

Verification
REQ-029 MWr, len=8, data bytes 1..7 = 01..07 -> FB(K), 40, 01..07, FD(K); done coincides with FD; TLP_count 0->1; 10 cycles total.
REQ-030 start with tlp_type=12 or tlp_len=3 -> err pulses once, data_out remains 00/datak=0, and TLP_count is unchanged.
REQ-031 start held high for 3 CplD frames of len=4 -> three 6-symbol frames, each separated by one 00 symbol; TLP_count=3.
REQ-032 reset asserted during BODY of a len=20 MRd -> next symbol is 00/datak=0, no FD is emitted, TLP_count=0, and ready=1.
REQ-033 256 consecutive len=4 Cpl frames -> TLP_count wraps to 0, and each frame's byte0 is 0A.
REQ-034 Loopback into the team's TLP detector with each of the 10 types -> the detector's type flag matches the sent type, and its count equals TLP_count.
